// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
interface rr_arbiter4_if #(
   parameter int unsigned N = 4
);
   logic [N-1:0] req;
   logic         done;
   logic [N-1:0] gnt;
   logic         busy;
   logic         timeout;

   // Requester side: raises requests and releases the grant
   modport master (
      output req,
      output done,
      input  gnt,
      input  busy,
      input  timeout
   );

   // Arbiter side: samples requests and drives the registered grant
   modport slave (
      input  req,
      input  done,
      output gnt,
      output busy,
      output timeout
   );
endinterface

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter producing a registered one-hot grant with hold timeout.
// Every grant is followed by at least one all-zero cycle so a downstream
// encoder never switches directly between two owners.
module rr_arbiter4 #(
   parameter int unsigned N       = 4,
   parameter int unsigned TIMEOUT = 16
) (
   input logic         clk,
   input logic         rst,
   rr_arbiter4_if.slave bus
);

   localparam int unsigned PTR_W   = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int unsigned TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [PTR_W-1:0]   own_q, own_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [N-1:0]       gnt_q, gnt_d;
   logic               busy_q, busy_d;
   logic               timeout_q, timeout_d;

   logic [PTR_W:0]     pick;
   logic               rel_done;
   logic               rel_drop;
   logic               rel_to;
   logic [PTR_W-1:0]   own_next;

   // First set request at or after p, wrapping; MSB flags that one was found
   function automatic logic [PTR_W:0] pick_next(input logic [N-1:0]     r,
                                                input logic [PTR_W-1:0] p);
      logic [PTR_W:0] res;
      int unsigned    k;
      res = '0;
      for (int i = 0; i < int'(N); i++) begin
         k = (32'(p) + 32'(i)) % N;
         if (!res[PTR_W] && r[PTR_W'(k)]) begin
            res = {1'b1, PTR_W'(k)};
         end
      end
      return res;
   endfunction

   // Release causes and the pointer position following the current owner
   assign pick     = pick_next(bus.req, ptr_q);
   assign rel_done = bus.done;
   assign rel_drop = !bus.req[own_q];
   assign rel_to   = (TIMEOUT != 0) && (cnt_q == CNT_W'(TO_LAST));
   assign own_next = (own_q == PTR_W'(N - 1)) ? '0 : own_q + 1'b1;

   // Next-state and output decode
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      own_d     = own_q;
      cnt_d     = cnt_q;
      gnt_d     = gnt_q;
      busy_d    = busy_q;
      timeout_d = 1'b0;
      case (state_q)
         IDLE: begin
            gnt_d  = '0;
            busy_d = 1'b0;
            if (pick[PTR_W]) begin
               own_d   = pick[PTR_W-1:0];
               gnt_d   = N'(1) << pick[PTR_W-1:0];
               busy_d  = 1'b1;
               cnt_d   = '0;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (rel_done || rel_drop || rel_to) begin
               state_d   = IDLE;
               gnt_d     = '0;
               busy_d    = 1'b0;
               ptr_d     = own_next;
               timeout_d = rel_to && !rel_done && !rel_drop;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and registered outputs, synchronous reset dominates
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         own_q     <= '0;
         cnt_q     <= '0;
         gnt_q     <= '0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         own_q     <= own_d;
         cnt_q     <= cnt_d;
         gnt_q     <= gnt_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.busy    = busy_q;
   assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Self-checking bench for rr_arbiter4: per-cycle vector table with a scoreboard.
module tb_rr_arbiter4;

   logic clk;
   logic rst;

   rr_arbiter4_if #(.N(4)) bus ();

   rr_arbiter4 #(.N(4), .TIMEOUT(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic       done;
      logic [3:0] gnt;
      logic       to;
   } vec_t;

   typedef struct {
      logic [3:0] gnt;
      logic       busy;
      logic       to;
      int         idx;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_vec;
   int   n_fail;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input logic r, input logic [3:0] q, input logic d,
                      input logic [3:0] g, input logic t);
      vec_t v;
      v.rst = r; v.req = q; v.done = d; v.gnt = g; v.to = t;
      vecs.push_back(v);
   endtask

   task automatic hold(input int n, input logic [3:0] q, input logic [3:0] g);
      for (int i = 0; i < n; i++) add(1'b0, q, 1'b0, g, 1'b0);
   endtask

   initial begin
      exp_t e;
      exp_t got;
      n_vec  = 0;
      n_fail = 0;
      rst      = 1'b1;
      bus.req  = '0;
      bus.done = 1'b0;

      // reset with all requests pending
      add(1, 4'b1111, 0, 4'b0000, 0);
      add(1, 4'b1111, 0, 4'b0000, 0);
      add(0, 4'b0000, 0, 4'b0000, 0);
      // single requester, 5-cycle hold, done, re-grant after one idle cycle
      add(0, 4'b0100, 0, 4'b0100, 0);
      hold(5, 4'b0100, 4'b0100);
      add(0, 4'b0100, 1, 4'b0000, 0);
      add(0, 4'b0100, 0, 4'b0100, 0);
      add(0, 4'b0100, 1, 4'b0000, 0);
      add(0, 4'b0000, 0, 4'b0000, 0);
      // full contention from ptr = 0
      add(1, 4'b0000, 0, 4'b0000, 0);
      for (int k = 0; k < 4; k++) begin
         add(0, 4'b1111, 0, 4'b0001 << k, 0);
         add(0, 4'b1111, 0, 4'b0001 << k, 0);
         add(0, 4'b1111, 1, 4'b0000, 0);
      end
      add(0, 4'b1111, 0, 4'b0001, 0);
      add(0, 4'b1111, 1, 4'b0000, 0);
      // wrap-around: ptr = 2 after releasing bit 1, then bits 0/1 requested
      add(0, 4'b0010, 0, 4'b0010, 0);
      add(0, 4'b0010, 1, 4'b0000, 0);
      add(0, 4'b0011, 0, 4'b0001, 0);
      add(0, 4'b0011, 1, 4'b0000, 0);
      add(0, 4'b0000, 0, 4'b0000, 0);
      // timeout: 16 cycles of grant, then a one-cycle pulse
      hold(16, 4'b1000, 4'b1000);
      add(0, 4'b1000, 0, 4'b0000, 1);
      // re-grant, done on the 16th cycle wins over the timeout
      hold(16, 4'b1000, 4'b1000);
      add(0, 4'b1000, 1, 4'b0000, 0);
      add(0, 4'b0000, 0, 4'b0000, 0);
      // abort by dropping the owner's request, next search starts at bit 2
      add(0, 4'b0010, 0, 4'b0010, 0);
      add(0, 4'b0010, 0, 4'b0010, 0);
      add(0, 4'b0000, 0, 4'b0000, 0);
      add(0, 4'b1111, 0, 4'b0100, 0);
      // reset mid-grant returns ptr to 0
      add(1, 4'b1111, 0, 4'b0000, 0);
      add(0, 4'b1111, 0, 4'b0001, 0);
      add(0, 4'b1111, 1, 4'b0000, 0);
      // done in IDLE is ignored; ptr stays at 1
      add(0, 4'b0000, 1, 4'b0000, 0);
      add(0, 4'b1111, 0, 4'b0010, 0);
      add(0, 4'b1111, 1, 4'b0000, 0);

      foreach (vecs[i]) begin
         rst      = vecs[i].rst;
         bus.req  = vecs[i].req;
         bus.done = vecs[i].done;
         e.gnt  = vecs[i].gnt;
         e.busy = |vecs[i].gnt;
         e.to   = vecs[i].to;
         e.idx  = i;
         sb.push_back(e);
         @(posedge clk);
         #1;
         got = sb.pop_front();
         n_vec++;
         if (bus.gnt !== got.gnt) begin
            n_fail++;
            $display("FAIL vec %0d gnt: got %b want %b", got.idx, bus.gnt, got.gnt);
         end
         if (bus.busy !== got.busy) begin
            n_fail++;
            $display("FAIL vec %0d busy: got %b want %b", got.idx, bus.busy, got.busy);
         end
         if (bus.timeout !== got.to) begin
            n_fail++;
            $display("FAIL vec %0d timeout: got %b want %b", got.idx, bus.timeout, got.to);
         end
         if ($countones(bus.gnt) > 1) begin
            n_fail++;
            $display("FAIL vec %0d onehot: got %b want popcount<=1", got.idx, bus.gnt);
         end
      end

      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard drain: got %0d left want 0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
